fir_input_frontend: RTL and testbench
=====================================

# fir_input_frontend

Pin-side front end placed directly upstream of the FIR filter core in the tile top level. Synchronises the asynchronous host strobe and coefficient-mode pins into `clk`, captures the 8-bit pin bus, and issues either a one-cycle sample-valid pulse with registered `x_n` or an indexed coefficient write. The core therefore sees only clean, single-cycle, clock-aligned events.

## Interface
Parameters:
- `DATA_W`, 8: width of pin bus, sample and coefficient.
- `NUM_TAPS`, 4: coefficients per load sequence; must be ≥ 2.
- `SYNC_STAGES`, 2: synchroniser depth; must be ≥ 2.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pin_data`  in  DATA_W  host data bus (ui_in); quasi-static.
- `pin_strobe`  in  1  host strobe (uio_in[7]); asynchronous to `clk`.
- `pin_set_coeffs`  in  1  coefficient-mode level (uio_in[6]); asynchronous.
- `x_n`  out  DATA_W  registered sample to FIR core.
- `s_axis_fir_tvalid`  out  1  one-cycle pulse: `x_n` is new.
- `coef_data`  out  DATA_W  registered coefficient value.
- `coef_addr`  out  $clog2(NUM_TAPS)  tap index of `coef_data`.
- `coef_we`  out  1  one-cycle coefficient write pulse.
- `coef_done`  out  1  one-cycle pulse: final tap written.
- `coef_abort`  out  1  one-cycle pulse: load ended early.
- `loading`  out  1  high while in LOAD.

## Operation
- Each asynchronous pin passes through a `SYNC_STAGES` flop chain, then an edge detector.
- Host protocol: `pin_data` is stable from at least SYNC_STAGES+1 cycles before a strobe rise until the strobe falls. `pin_data` is sampled unsynchronised when the strobe edge is detected.
- FSM states: RUN (reset state) and LOAD. Index counter `idx` has reset value 0.
- RUN, strobe edge: `x_n` <= `pin_data`, `s_axis_fir_tvalid` pulses.
- RUN → LOAD on a rising edge of synced set_coeffs. Sets `idx`=0 and `loading`=1.
- LOAD, strobe edge:
  - `coef_data` <= `pin_data`, `coef_addr` <= `idx`, `coef_we` pulses.
  - If `idx`==NUM_TAPS-1: `coef_done` pulses together with `coef_we`, `idx`=0, return to RUN.
  - Else `idx`+1.
- LOAD, falling edge of synced set_coeffs before the last tap: `coef_abort` pulses, `idx`=0, return to RUN. Taps already written stay written.
- No `s_axis_fir_tvalid` is issued while in LOAD.
- Simultaneous events:
  - Set-rise and strobe edge in the same cycle: enter LOAD and write that strobe as tap 0; `idx` becomes 1.
  - Set-fall and final-tap strobe in the same cycle: the write completes, `coef_done` pulses, `coef_abort` does not.
  - Set-fall and non-final strobe in the same cycle: the write completes, then abort.
- A pin already high when reset is released counts as a rising edge exactly once after release.

## Timing
- Reset values: all outputs 0. `x_n`, `coef_data` and `coef_addr` = 0, all pulses low, `loading`=0. State RUN, `idx`=0, all sync flops 0.
- Reset mid-load: return to RUN immediately. No `coef_done` or `coef_abort` pulse.
- Latency: if `pin_strobe` is first sampled high at edge k, the output pulse is high for exactly the cycle after edge k+SYNC_STAGES.
- `loading` rises on the same edge as a set-rise would fire a strobe pulse, and falls on the edge of `coef_done` or `coef_abort`.
- All pulses last exactly one cycle regardless of how long the pin is held.
- The strobe must be low for ≥ SYNC_STAGES+1 cycles between events; shorter gaps may be merged.
- `x_n`, `coef_data` and `coef_addr` hold their value between events.

## Configuration
- `FIR_FRONTEND_GLITCH_FILTER_EN` defined:
  - The synced strobe and set_coeffs must read high on 2 consecutive cycles before an edge is declared. Falls need 2 consecutive lows.
  - Single-cycle synced glitches are ignored.
  - Latency increases by one cycle (pulse follows edge k+SYNC_STAGES+1).
- Undefined: edge declared on a single synced transition, as specified above.

## Structure
- Shared package `fir_pkg`:
  - State enum `fir_fe_state_t` {RUN, LOAD}.
  - Constants `FIR_DATA_W`=8, `FIR_NUM_TAPS`=4, `FIR_SYNC_STAGES`=2. These are parameter defaults shared with the FIR core.
- Sub-module `fir_pin_sync`: synchroniser chain, optional glitch filter and edge detector. Outputs `level`, `rise`, `fall`. Instantiated twice (strobe, set_coeffs).

## Test plan
- Reset, then `pin_data`=0x5A and strobe high for 5 cycles → `x_n`=0x5A, `s_axis_fir_tvalid` high exactly once, in the cycle after edge k+2.
- Set_coeffs high, then strobes with 0x01, 0x02, 0x03, 0x04 → `coef_we` ×4 with `coef_addr` 0..3. `coef_done` coincides with addr 3. `loading` returns to 0. No tvalid.
- Set_coeffs high, 2 strobes, then set_coeffs low → 2 writes, `coef_abort` once. The next strobe of 0x77 yields tvalid with `x_n`=0x77.
- Set_coeffs rise and strobe rise on the same clk edge with `pin_data`=0x11 → `coef_addr`=0, `coef_data`=0x11. The next strobe writes addr 1.
- Assert `rst_n` low mid-load after tap 1 → all outputs 0, no done/abort. After release, a strobe produces a tvalid sample.
- With `FIR_FRONTEND_GLITCH_FILTER_EN`: a 1-cycle strobe pulse → no output. A 4-cycle pulse → one tvalid, the cycle after edge k+3.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: state type and parameter defaults shared by the FIR front end and FIR core.
package fir_pkg;
  typedef enum logic {RUN, LOAD} fir_fe_state_t;
  localparam int FIR_DATA_W = 8;
  localparam int FIR_NUM_TAPS = 4;
  localparam int FIR_SYNC_STAGES = 2;
endpackage

// File: rtl/fir_pin_sync.sv
// fir_pin_sync: synchroniser chain plus edge detector for one asynchronous pin.
// FIR_FRONTEND_GLITCH_FILTER_EN: a level change must persist for 2 synced cycles before it is accepted.
module fir_pin_sync
  import fir_pkg::*;
#(
  parameter int SYNC_STAGES = FIR_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], pin};
`ifdef FIR_FRONTEND_GLITCH_FILTER_EN
  logic hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold <= 1'b0;
    else hold <= sync[SYNC_STAGES-1];
  // accept a new level only once two consecutive synced samples agree
  assign level = (sync[SYNC_STAGES-1] == hold) ? hold : prev;
`else
  assign level = sync[SYNC_STAGES-1];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 1'b0;
    else prev <= level;
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/fir_input_frontend.sv
// fir_input_frontend: turns host pins into clean sample-valid pulses or indexed coefficient writes.
// FIR_FRONTEND_GLITCH_FILTER_EN enables the 2-cycle debounce in both pin synchronisers.
module fir_input_frontend
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int SYNC_STAGES = FIR_SYNC_STAGES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           pin_data,
  input  logic                        pin_strobe,
  input  logic                        pin_set_coeffs,
  output logic [DATA_W-1:0]           x_n,
  output logic                        s_axis_fir_tvalid,
  output logic [DATA_W-1:0]           coef_data,
  output logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  output logic                        coef_we,
  output logic                        coef_done,
  output logic                        coef_abort,
  output logic                        loading
);
  localparam int AW = $clog2(NUM_TAPS);
  localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);
  fir_fe_state_t state, state_n;
  logic [AW-1:0] idx, idx_n, widx, addr_n;
  logic [DATA_W-1:0] x_nx, cd_n;
  logic wr, tv_n, we_n, done_n, abort_n;
  logic st_level, st_rise, st_fall, set_level, set_rise, set_fall;
  logic unused_levels;
  fir_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_strobe (
    .clk(clk), .rst_n(rst_n), .pin(pin_strobe),
    .level(st_level), .rise(st_rise), .fall(st_fall)
  );
  fir_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_set (
    .clk(clk), .rst_n(rst_n), .pin(pin_set_coeffs),
    .level(set_level), .rise(set_rise), .fall(set_fall)
  );
  assign unused_levels = ^{st_level, st_fall, set_level};
  // a strobe coinciding with set-rise is already a tap-0 write
  always_comb begin
    wr = st_rise & ((state == LOAD) | set_rise);
    widx = (state == LOAD) ? idx : '0;
    tv_n = st_rise & ~wr;
    we_n = wr;
    x_nx = tv_n ? pin_data : x_n;
    cd_n = wr ? pin_data : coef_data;
    addr_n = wr ? widx : coef_addr;
    state_n = ((state == RUN) & set_rise) ? LOAD : state;
    idx_n = wr ? widx + AW'(1) : ((state == RUN) ? '0 : idx);
    done_n = wr & (widx == LAST);
    abort_n = ~done_n & (state == LOAD) & set_fall;
    if (done_n | abort_n) begin
      state_n = RUN;
      idx_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      idx <= '0;
      x_n <= '0;
      coef_data <= '0;
      coef_addr <= '0;
      s_axis_fir_tvalid <= 1'b0;
      coef_we <= 1'b0;
      coef_done <= 1'b0;
      coef_abort <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      x_n <= x_nx;
      coef_data <= cd_n;
      coef_addr <= addr_n;
      s_axis_fir_tvalid <= tv_n;
      coef_we <= we_n;
      coef_done <= done_n;
      coef_abort <= abort_n;
    end
  assign loading = (state == LOAD);
endmodule

// File: tb/tb_fir_input_frontend.sv
// tb_fir_input_frontend: randomized pin stimulus checked each cycle against a history-based reference model.
module tb_fir_input_frontend;
  localparam int S = 2;
  localparam int N = 4;
`ifdef FIR_FRONTEND_GLITCH_FILTER_EN
  localparam int GF = 1;
`else
  localparam int GF = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] pin_data = '0;
  logic pin_strobe = 1'b0;
  logic pin_set_coeffs = 1'b0;
  logic [7:0] x_n, coef_data;
  logic [1:0] coef_addr;
  logic s_axis_fir_tvalid, coef_we, coef_done, coef_abort, loading;
  fir_input_frontend dut (
    .clk(clk), .rst_n(rst_n), .pin_data(pin_data), .pin_strobe(pin_strobe),
    .pin_set_coeffs(pin_set_coeffs), .x_n(x_n), .s_axis_fir_tvalid(s_axis_fir_tvalid),
    .coef_data(coef_data), .coef_addr(coef_addr), .coef_we(coef_we),
    .coef_done(coef_done), .coef_abort(coef_abort), .loading(loading)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, ecount);
    end
  endtask
  // reference: accepted pin levels per edge, delayed by the synchroniser depth
  bit hs [S+2];
  bit hc [S+2];
  bit rs_last, rc_last;
  logic [7:0] m_x, m_cd;
  int m_idx, m_ca;
  bit m_load, m_tv, m_we, m_done, m_ab;
  int ecount = 0;
  int tv_count = 0, we_count = 0, done_count = 0, abort_count = 0, last_tv_edge = -1;
  always @(posedge clk) begin
    bit fs, fc, st, sr, sf, was;
    ecount++;
    if (!rst_n) begin
      for (int i = 0; i < S + 2; i++) begin
        hs[i] = 0;
        hc[i] = 0;
      end
      rs_last = 0; rc_last = 0;
      m_x = 0; m_cd = 0; m_ca = 0; m_idx = 0; m_load = 0;
      m_tv = 0; m_we = 0; m_done = 0; m_ab = 0;
    end else begin
      fs = (GF != 0 && pin_strobe != rs_last) ? hs[S+1] : pin_strobe;
      fc = (GF != 0 && pin_set_coeffs != rc_last) ? hc[S+1] : pin_set_coeffs;
      rs_last = pin_strobe;
      rc_last = pin_set_coeffs;
      for (int i = 0; i < S + 1; i++) begin
        hs[i] = hs[i+1];
        hc[i] = hc[i+1];
      end
      hs[S+1] = fs;
      hc[S+1] = fc;
      st = hs[1] & ~hs[0];
      sr = hc[1] & ~hc[0];
      sf = ~hc[1] & hc[0];
      m_tv = 0; m_we = 0; m_done = 0; m_ab = 0;
      was = m_load;
      if (!was && sr) begin
        m_load = 1;
        m_idx = 0;
      end
      if (m_load && st) begin
        m_we = 1; m_cd = pin_data; m_ca = m_idx;
        if (m_idx == N - 1) begin
          m_done = 1; m_load = 0; m_idx = 0;
        end else m_idx++;
      end else if (st) begin
        m_tv = 1; m_x = pin_data;
      end
      if (was && m_load && sf) begin
        m_ab = 1; m_load = 0; m_idx = 0;
      end
    end
    #1;
    check("x_n", x_n, m_x);
    check("tvalid", s_axis_fir_tvalid, m_tv);
    check("coef_data", coef_data, m_cd);
    check("coef_addr", coef_addr, m_ca);
    check("coef_we", coef_we, m_we);
    check("coef_done", coef_done, m_done);
    check("coef_abort", coef_abort, m_ab);
    check("loading", loading, m_load);
    if (s_axis_fir_tvalid) begin
      tv_count++;
      last_tv_edge = ecount;
    end
    if (coef_we) we_count++;
    if (coef_done) done_count++;
    if (coef_abort) abort_count++;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic strobe(input logic [7:0] d, input int len, output int k);
    pin_data = d;
    cyc(S + 2);
    pin_strobe = 1'b1;
    k = ecount + 1;
    cyc(len);
    pin_strobe = 1'b0;
    cyc(S + 4);
  endtask
  task automatic set_pin(input logic v);
    pin_set_coeffs = v;
    cyc(S + 4);
  endtask
  initial begin
    int k, tv0, we0, dn0, ab0, op;
    cyc(3);
    check("rst_x_n", x_n, 0);
    check("rst_loading", loading, 0);
    rst_n = 1'b1;
    cyc(2);
    tv0 = tv_count;
    strobe(8'h5A, 5, k);
    check("s1_tv_once", tv_count - tv0, 1);
    check("s1_latency", last_tv_edge, k + S + GF);
    check("s1_x_n", x_n, 8'h5A);
    tv0 = tv_count; we0 = we_count; dn0 = done_count;
    set_pin(1'b1);
    for (int i = 1; i <= N; i++) strobe(8'(i), 3, k);
    check("s2_we", we_count - we0, N);
    check("s2_done", done_count - dn0, 1);
    check("s2_tv", tv_count - tv0, 0);
    check("s2_addr", coef_addr, N - 1);
    set_pin(1'b0);
    we0 = we_count; ab0 = abort_count; tv0 = tv_count;
    set_pin(1'b1);
    strobe(8'hA1, 3, k);
    strobe(8'hA2, 3, k);
    set_pin(1'b0);
    check("s3_we", we_count - we0, 2);
    check("s3_abort", abort_count - ab0, 1);
    strobe(8'h77, 3, k);
    check("s3_tv", tv_count - tv0, 1);
    check("s3_x_n", x_n, 8'h77);
    pin_data = 8'h11;
    cyc(S + 2);
    pin_set_coeffs = 1'b1;
    pin_strobe = 1'b1;
    cyc(3);
    pin_strobe = 1'b0;
    cyc(S + 4);
    check("s4_addr0", coef_addr, 0);
    check("s4_data0", coef_data, 8'h11);
    strobe(8'h22, 3, k);
    check("s4_addr1", coef_addr, 1);
    set_pin(1'b0);
    set_pin(1'b1);
    strobe(8'h31, 3, k);
    strobe(8'h32, 3, k);
    dn0 = done_count; ab0 = abort_count; tv0 = tv_count;
    rst_n = 1'b0;
    pin_set_coeffs = 1'b0;
    cyc(3);
    check("s5_coef_data", coef_data, 0);
    check("s5_loading", loading, 0);
    rst_n = 1'b1;
    cyc(S + 4);
    check("s5_no_done", done_count - dn0, 0);
    check("s5_no_abort", abort_count - ab0, 0);
    strobe(8'h44, 3, k);
    check("s5_tv", tv_count - tv0, 1);
`ifdef FIR_FRONTEND_GLITCH_FILTER_EN
    tv0 = tv_count;
    strobe(8'h55, 1, k);
    check("gf_glitch", tv_count - tv0, 0);
    strobe(8'h66, 4, k);
    check("gf_tv", tv_count - tv0, 1);
    check("gf_latency", last_tv_edge, k + S + 1);
`endif
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 11);
      if (i % 67 == 66) begin
        @(negedge clk);
        rst_n = 1'b0;
        cyc($urandom_range(1, 3));
        rst_n = 1'b1;
        cyc(1);
      end else if (op <= 6) strobe(8'($urandom), $urandom_range(1, 5), k);
      else if (op <= 8) set_pin(~pin_set_coeffs);
      else if (op == 9) begin
        pin_data = 8'($urandom);
        cyc(S + 2);
        pin_set_coeffs = ~pin_set_coeffs;
        pin_strobe = 1'b1;
        cyc($urandom_range(1, 4));
        pin_strobe = 1'b0;
        cyc(S + 4);
      end else begin
        pin_set_coeffs = ~pin_set_coeffs;
        cyc($urandom_range(1, 2));
        pin_set_coeffs = ~pin_set_coeffs;
        cyc(S + 4);
      end
    end
    cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
